// File: rtl/fpu_buf_pkg.sv
// Shared types and constants for the FPU result buffer.
// The entry struct is the unit stored per FIFO slot.
package fpu_buf_pkg;

    localparam int ENTRY_RES_W  = 32;
    localparam int ENTRY_FFLG_W = 5;
    localparam int ENTRY_IFLG_W = 3;
    localparam int ENTRY_USER_W = 4;

    typedef struct packed {
        logic [ENTRY_RES_W-1:0]  result;
        logic [ENTRY_FFLG_W-1:0] fflags;
        logic [ENTRY_IFLG_W-1:0] iflags;
        logic [ENTRY_USER_W-1:0] user;
        logic                    error;
    } fpu_res_entry_t;

    localparam int                    DROP_CNT_W   = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

endpackage

// File: rtl/fpu_res_fifo_mem.sv
// Register array with one synchronous write port and one asynchronous read port.
// Contents are deliberately left unreset.
module fpu_res_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 45
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fpu_result_buffer.sv
// Output FIFO behind the FPU: converts stall-based flow control into a valid/ready
// stream, raises stall early enough to absorb in-flight results, and counts drops.
module fpu_result_buffer
    import fpu_buf_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int SKID   = 3,
    parameter int RES_W  = 32,
    parameter int FFLG_W = 5,
    parameter int IFLG_W = 3,
    parameter int USER_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fpu_valid_o,
    input  logic [RES_W-1:0]           fpu_result_o,
    input  logic [FFLG_W-1:0]          fpu_fflags_o,
    input  logic [IFLG_W-1:0]          fpu_iflags_o,
    input  logic [USER_W-1:0]          fpu_user_o,
    input  logic                       fpu_error_o,
    output logic                       fpu_stall_i,
    input  logic                       flush_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RES_W-1:0]           out_result,
    output logic [FFLG_W-1:0]          out_fflags,
    output logic [IFLG_W-1:0]          out_iflags,
    output logic [USER_W-1:0]          out_user,
    output logic                       out_error,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic [DROP_CNT_W-1:0]      drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_TH  = CNT_W'(DEPTH - SKID);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;
    fpu_res_entry_t   wr_entry;
    fpu_res_entry_t   rd_entry;

    assign push  = fpu_valid_o;
    assign pop   = out_valid && out_ready;
    assign full  = (count == FULL_CNT);
    // A full FIFO still accepts a beat when the head retires on the same edge.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        count_next = count;
        case ({wr_en, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        wr_entry        = '0;
        wr_entry.result = fpu_result_o;
        wr_entry.fflags = fpu_fflags_o;
        wr_entry.iflags = fpu_iflags_o;
        wr_entry.user   = fpu_user_o;
        wr_entry.error  = fpu_error_o;
    end

    fpu_res_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fpu_res_entry_t))
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en && !flush_i),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fpu_stall_i <= 1'b0;
            overflow_o  <= 1'b0;
            drop_cnt_o  <= '0;
        end else if (flush_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fpu_stall_i <= 1'b0;
            overflow_o  <= 1'b0;
            drop_cnt_o  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count_next;
            fpu_stall_i <= (count_next >= STALL_TH);
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != DROP_CNT_MAX) begin
                    drop_cnt_o <= drop_cnt_o + 1'b1;
                end
            end
        end
    end

    assign count_o    = count;
    assign out_valid  = (count != '0);
    assign out_result = out_valid ? rd_entry.result : '0;
    assign out_fflags = out_valid ? rd_entry.fflags : '0;
    assign out_iflags = out_valid ? rd_entry.iflags : '0;
    assign out_user   = out_valid ? rd_entry.user   : '0;
    assign out_error  = out_valid ? rd_entry.error  : 1'b0;

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Scoreboard bench for fpu_result_buffer: a queue-based reference model records
// accepted beats, and a negedge monitor compares every visible output against it.
module tb_fpu_result_buffer;
    import fpu_buf_pkg::*;

    localparam int DEPTH = 8;
    localparam int SKID  = 3;

    logic        clk;
    logic        rst_n;
    logic        fpu_valid_o;
    logic [31:0] fpu_result_o;
    logic [4:0]  fpu_fflags_o;
    logic [2:0]  fpu_iflags_o;
    logic [3:0]  fpu_user_o;
    logic        fpu_error_o;
    logic        fpu_stall_i;
    logic        flush_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_fflags;
    logic [2:0]  out_iflags;
    logic [3:0]  out_user;
    logic        out_error;
    logic [3:0]  count_o;
    logic        overflow_o;
    logic [7:0]  drop_cnt_o;

    fpu_result_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fpu_valid_o  (fpu_valid_o),
        .fpu_result_o (fpu_result_o),
        .fpu_fflags_o (fpu_fflags_o),
        .fpu_iflags_o (fpu_iflags_o),
        .fpu_user_o   (fpu_user_o),
        .fpu_error_o  (fpu_error_o),
        .fpu_stall_i  (fpu_stall_i),
        .flush_i      (flush_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_fflags   (out_fflags),
        .out_iflags   (out_iflags),
        .out_user     (out_user),
        .out_error    (out_error),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of accepted beats plus occupancy and drop bookkeeping.
    fpu_res_entry_t exp_q[$];
    int             m_count = 0;
    logic           m_ovf   = 1'b0;
    int             m_drop  = 0;
    logic           m_stall = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush_i) begin
            exp_q.delete();
            m_count = 0;
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_stall = 1'b0;
        end else begin
            automatic bit popping = (m_count != 0) && out_ready;
            automatic fpu_res_entry_t e;
            e.result = fpu_result_o;
            e.fflags = fpu_fflags_o;
            e.iflags = fpu_iflags_o;
            e.user   = fpu_user_o;
            e.error  = fpu_error_o;
            if (popping) m_count = m_count - 1;
            if (fpu_valid_o) begin
                if (m_count < DEPTH) begin
                    exp_q.push_back(e);
                    m_count = m_count + 1;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop = m_drop + 1;
                end
            end
            m_stall = (m_count >= DEPTH - SKID);
        end
    end

    // Monitor: mid-cycle comparison of every output against the model.
    always @(negedge clk) begin
        assert (count_o <= 4'(DEPTH)) else $error("occupancy above DEPTH: %0d", count_o);
        check("count_bound", 64'(count_o <= 4'(DEPTH)), 64'd1);
        check("count",    64'(count_o),    64'(m_count));
        check("valid",    64'(out_valid),  64'(m_count != 0));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
        check("stall",    64'(fpu_stall_i), 64'(m_stall));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("head_present", 64'd0, 64'd1);
            end else begin
                check("head_data",
                      64'({out_result, out_fflags, out_iflags, out_user, out_error}),
                      64'(exp_q[0]));
                if (out_ready && rst_n) void'(exp_q.pop_front());
            end
        end else begin
            check("idle_zero",
                  64'({out_result, out_fflags, out_iflags, out_user, out_error}), 64'd0);
        end
    end

    task automatic drive(input logic v, input logic rdy, input logic fl);
        fpu_valid_o  = v;
        out_ready    = rdy;
        flush_i      = fl;
        fpu_result_o = $urandom;
        fpu_fflags_o = 5'($urandom);
        fpu_iflags_o = 3'($urandom);
        fpu_user_o   = 4'($urandom);
        fpu_error_o  = 1'($urandom);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        #12 rst_n = 1'b1;
        step(1);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);

        // Single beat with a consumer always ready.
        drive(1'b1, 1'b1, 1'b0);
        fpu_result_o = 32'h3F80_0000;
        fpu_user_o   = 4'h5;
        step(1);
        drive(1'b0, 1'b1, 1'b0);
        check("t1_valid",  64'(out_valid),  64'd1);
        check("t1_result", 64'(out_result), 64'h3F80_0000);
        check("t1_user",   64'(out_user),   64'h5);
        step(1);
        check("t1_empty",  64'(count_o), 64'd0);

        // Stall threshold and fill.
        for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 1'b0); step(1); end
        check("t2_nostall4", 64'(fpu_stall_i), 64'd0);
        drive(1'b1, 1'b0, 1'b0); step(1);
        check("t2_stall5", 64'(fpu_stall_i), 64'd1);
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b0); step(1); end
        check("t2_full", 64'(count_o), 64'd8);
        check("t2_noovf", 64'(overflow_o), 64'd0);

        // Overflow, then drain in order.
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b0); step(1); end
        check("t3_ovf",  64'(overflow_o), 64'd1);
        check("t3_drop", 64'(drop_cnt_o), 64'd3);
        check("t3_cnt",  64'(count_o),    64'd8);
        drive(1'b0, 1'b1, 1'b0); step(8);
        check("t3_drained", 64'(count_o), 64'd0);
        drive(1'b0, 1'b0, 1'b1); step(1);

        // Full with simultaneous push and pop, pointers wrapping.
        for (int i = 0; i < 8; i++) begin drive(1'b1, 1'b0, 1'b0); step(1); end
        for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b1, 1'b0); step(1); end
        check("t4_cnt",  64'(count_o),    64'd8);
        check("t4_drop", 64'(drop_cnt_o), 64'd0);

        // Flush with a concurrent push.
        for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0, 1'b0); step(1); end
        drive(1'b0, 1'b1, 1'b0); step(2);
        check("t5_pre_cnt",  64'(count_o),    64'd6);
        check("t5_pre_drop", 64'(drop_cnt_o), 64'd2);
        drive(1'b1, 1'b0, 1'b1); step(1);
        drive(1'b0, 1'b0, 1'b0);
        check("t5_cnt",   64'(count_o),     64'd0);
        check("t5_valid", 64'(out_valid),   64'd0);
        check("t5_ovf",   64'(overflow_o),  64'd0);
        check("t5_drop",  64'(drop_cnt_o),  64'd0);
        check("t5_stall", 64'(fpu_stall_i), 64'd0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 1'b0); step(1); end
        drive(1'b0, 1'b0, 1'b0);
        check("t6_pre_cnt", 64'(count_o), 64'd4);
        #1 rst_n = 1'b0;
        #1;
        check("t6_cnt",   64'(count_o),     64'd0);
        check("t6_valid", 64'(out_valid),   64'd0);
        check("t6_stall", 64'(fpu_stall_i), 64'd0);
        check("t6_data",  64'(out_result),  64'd0);
        #3 rst_n = 1'b1;
        step(1);
        drive(1'b1, 1'b1, 1'b0);
        fpu_result_o = 32'h4000_0000;
        step(1);
        drive(1'b0, 1'b1, 1'b0);
        check("t6_first", 64'(out_result), 64'h4000_0000);
        step(2);

        // Randomized traffic with phases biased toward fill and drain.
        for (int ph = 0; ph < 6; ph++) begin
            automatic int vp = (ph % 2 == 0) ? 90 : 40;
            automatic int rp = (ph % 3 == 0) ? 20 : 70;
            for (int c = 0; c < 500; c++) begin
                drive(1'($urandom_range(99) < vp), 1'($urandom_range(99) < rp),
                      1'($urandom_range(99) == 0));
                step(1);
            end
        end
        drive(1'b0, 1'b1, 1'b0);
        step(12);
        check("final_empty", 64'(count_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
